// File: rtl/char_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// char_motion_ctrl_pkg
//   Shared types for the character motion/collision engine.
//   - vfsm_e  : vertical motion state (GROUND / JUMP / FALL)
//   - probe_e : neighbour-probe sequencer state
//   - MOV_*   : bit positions inside the {up,down,left,right} keypad vector.
//               The same indices select the matching free flag, so a probe
//               direction and its keypad bit always share one number.
//   - next_probe / probe_dir : probe sequencing helpers
// -----------------------------------------------------------------------------
package char_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        FALL   = 2'd2
    } vfsm_e;

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_U     = 3'd1,
        P_D     = 3'd2,
        P_L     = 3'd3,
        P_R     = 3'd4,
        P_APPLY = 3'd5
    } probe_e;

    localparam int MOV_U = 3;
    localparam int MOV_D = 2;
    localparam int MOV_L = 1;
    localparam int MOV_R = 0;

    // Probe order: U, D, L, R, then one apply cycle.
    function automatic probe_e next_probe(input probe_e s);
        case (s)
            P_IDLE:  return P_U;
            P_U:     return P_D;
            P_D:     return P_L;
            P_L:     return P_R;
            P_R:     return P_APPLY;
            default: return P_IDLE;
        endcase
    endfunction

    // Free-flag index probed in a given state (don't-care outside U/D/L/R).
    function automatic logic [1:0] probe_dir(input probe_e s);
        case (s)
            P_U:     return 2'(MOV_U);
            P_D:     return 2'(MOV_D);
            P_L:     return 2'(MOV_L);
            default: return 2'(MOV_R);
        endcase
    endfunction

endpackage

// File: rtl/char_collision_probe.sv
// -----------------------------------------------------------------------------
// char_collision_probe
//   Reads the four neighbour tiles of the character from an external block RAM
//   with 1-cycle read latency and reports which neighbours are free.
//   Each probe phase takes two cycles: cycle 1 presents the address, cycle 2
//   captures the RAM data. Points outside the legal play field are reported as
//   blocked; the RAM is still read there but its data is discarded.
//
// Ports
//   clk_i       in   system clock
//   rst_ni      in   synchronous active-low reset
//   start_i     in   motion tick, starts a probe sequence from P_IDLE
//   x_i, y_i    in   current character position (stable during a probe)
//   blk_addr_o  out  tile RAM address {row, col}
//   blk_data_i  in   tile RAM data, 1 = solid
//   free_o      out  free flags indexed by MOV_U/D/L/R
//   apply_o     out  1-cycle pulse: free_o is complete, apply the motion step
//   state_o     out  probe sequencer state (debug)
// -----------------------------------------------------------------------------
module char_collision_probe
    import char_motion_ctrl_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 960,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 400,
    parameter int TILE_SHIFT = 5,
    parameter int COL_BITS   = 5,
    parameter int ROW_BITS   = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [COORD_W-1:0]           x_i,
    input  logic [COORD_W-1:0]           y_i,
    output logic [ROW_BITS+COL_BITS-1:0] blk_addr_o,
    input  logic                         blk_data_i,
    output logic [3:0]                   free_o,
    output logic                         apply_o,
    output probe_e                       state_o
);

    localparam int AW = ROW_BITS + COL_BITS;

    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] XMIN_C = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMIN_C = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);

    // Tile address of a pixel; row/col are simply truncated to the RAM size.
    function automatic logic [AW-1:0] tile_addr(input logic [COORD_W-1:0] px,
                                                input logic [COORD_W-1:0] py);
        return {ROW_BITS'(py >> TILE_SHIFT), COL_BITS'(px >> TILE_SHIFT)};
    endfunction

    probe_e          state_q, state_d;
    logic            phase_q, phase_d;     // 0: address cycle, 1: capture cycle
    logic [AW-1:0]   addr_q,  addr_d;
    logic [3:0]      free_q,  free_d;

    logic [AW-1:0]   pt_addr [4];
    logic [3:0]      in_bounds;
    logic [1:0]      cur_dir;
    logic [1:0]      nxt_dir;

    // Neighbour points. The position is always legal, so only the coordinate
    // that moves needs a bounds check, and the strict compares keep the
    // wrapped values (e.g. y-1 at Y_MIN) from ever being treated as free.
    always_comb begin
        pt_addr[MOV_U] = tile_addr(x_i, y_i - ONE);
        pt_addr[MOV_D] = tile_addr(x_i, y_i + ONE);
        pt_addr[MOV_L] = tile_addr(x_i - ONE, y_i);
        pt_addr[MOV_R] = tile_addr(x_i + ONE, y_i);
        in_bounds[MOV_U] = (y_i > YMIN_C);
        in_bounds[MOV_D] = (y_i < YMAX_C);
        in_bounds[MOV_L] = (x_i > XMIN_C);
        in_bounds[MOV_R] = (x_i < XMAX_C);
    end

    assign cur_dir = probe_dir(state_q);
    assign nxt_dir = probe_dir(next_probe(state_q));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        free_d  = free_q;
        unique case (state_q)
            P_IDLE: begin
                if (start_i) begin
                    state_d = P_U;
                    phase_d = 1'b0;
                    addr_d  = pt_addr[MOV_U];
                end
            end
            P_U, P_D, P_L, P_R: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    free_d[cur_dir] = in_bounds[cur_dir] & ~blk_data_i;
                    phase_d         = 1'b0;
                    state_d         = next_probe(state_q);
                    // Load the next neighbour's address while capturing this one.
                    if (state_q != P_R) begin
                        addr_d = pt_addr[nxt_dir];
                    end
                end
            end
            P_APPLY: state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= P_IDLE;
            phase_q <= 1'b0;
            addr_q  <= '0;
            free_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            free_q  <= free_d;
        end
    end

    assign blk_addr_o = addr_q;
    assign free_o     = free_q;
    assign apply_o    = (state_q == P_APPLY);
    assign state_o    = state_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// -----------------------------------------------------------------------------
// char_motion_ctrl
//   Character motion/collision engine. A divider turns sys_clk into a motion
//   tick; each tick the collision probe reads the four neighbour tiles, and in
//   the apply cycle the character walks left/right and the vertical FSM
//   (GROUND/JUMP/FALL) moves it up or down. Both updates use the position that
//   was probed, so they are computed in the same cycle from the same flags.
//
// Ports
//   sys_clk    in   system clock
//   rst_n      in   synchronous active-low reset
//   mov        in   {up,down,left,right} keypad levels (down is reserved)
//   blk_addr   out  tile RAM address {row, col}
//   blk_data   in   tile RAM data, 1 = solid, valid 1 cycle after blk_addr
//   char_x     out  character X
//   char_y     out  character Y
//   on_ground  out  vertical FSM in GROUND
//   jumping    out  vertical FSM in JUMP
//   tick       out  1-cycle pulse at the start of each motion tick
// -----------------------------------------------------------------------------
module char_motion_ctrl
    import char_motion_ctrl_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 960,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 400,
    parameter int START_X    = 244,
    parameter int START_Y    = 300,
    parameter int TICK_DIV   = 200000,
    parameter int JUMP_H     = 48,
    parameter int TILE_SHIFT = 5,
    parameter int COL_BITS   = 5,
    parameter int ROW_BITS   = 5
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic [3:0]                   mov,
    output logic [ROW_BITS+COL_BITS-1:0] blk_addr,
    input  logic                         blk_data,
    output logic [COORD_W-1:0]           char_x,
    output logic [COORD_W-1:0]           char_y,
    output logic                         on_ground,
    output logic                         jumping,
    output logic                         tick
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int JCNT_W = $clog2(JUMP_H + 1);

    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [JCNT_W-1:0]  JUMP_H_C  = JCNT_W'(JUMP_H);
    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
    localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               tick_q,  tick_d;
    logic [COORD_W-1:0] x_q,     x_d;
    logic [COORD_W-1:0] y_q,     y_d;
    vfsm_e              vstate_q, vstate_d;
    logic [JCNT_W-1:0]  jcnt_q,  jcnt_d;
    logic               on_ground_q, jumping_q;

    logic [3:0]         free;
    logic               apply;
    probe_e             probe_state;

    // The down key has no function yet; the probe state is a debug tap.
    logic               unused_mov_down;
    probe_e             unused_probe_state;
    assign unused_mov_down    = mov[MOV_D];
    assign unused_probe_state = probe_state;

    char_collision_probe #(
        .COORD_W    (COORD_W),
        .X_MIN      (X_MIN),
        .X_MAX      (X_MAX),
        .Y_MIN      (Y_MIN),
        .Y_MAX      (Y_MAX),
        .TILE_SHIFT (TILE_SHIFT),
        .COL_BITS   (COL_BITS),
        .ROW_BITS   (ROW_BITS)
    ) u_probe (
        .clk_i      (sys_clk),
        .rst_ni     (rst_n),
        .start_i    (tick_q),
        .x_i        (x_q),
        .y_i        (y_q),
        .blk_addr_o (blk_addr),
        .blk_data_i (blk_data),
        .free_o     (free),
        .apply_o    (apply),
        .state_o    (probe_state)
    );

    // Tick divider: tick is high for the cycle in which the counter is back at 0.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == TICK_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Motion step. The keypad is only looked at here, in the apply cycle.
    // Free flags already include the field bounds, so no step can wrap.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vstate_d = vstate_q;
        jcnt_d   = jcnt_q;
        if (apply) begin
            if (mov[MOV_L] && !mov[MOV_R] && free[MOV_L]) begin
                x_d = x_q - ONE;
            end else if (mov[MOV_R] && !mov[MOV_L] && free[MOV_R]) begin
                x_d = x_q + ONE;
            end

            unique case (vstate_q)
                GROUND: begin
                    if (mov[MOV_U] && free[MOV_U]) begin
                        vstate_d = JUMP;
                        y_d      = y_q - ONE;
                        jcnt_d   = JCNT_W'(1);
                    end else if (free[MOV_D]) begin
                        vstate_d = FALL;
                        y_d      = y_q + ONE;
                    end
                end
                JUMP: begin
                    if (free[MOV_U] && (jcnt_q < JUMP_H_C)) begin
                        y_d    = y_q - ONE;
                        jcnt_d = jcnt_q + JCNT_W'(1);
                    end else begin
                        // Apex or ceiling: turn over without moving this tick.
                        vstate_d = FALL;
                        jcnt_d   = '0;
                    end
                end
                FALL: begin
                    if (free[MOV_D]) begin
                        y_d = y_q + ONE;
                    end else begin
                        vstate_d = GROUND;
                    end
                end
                default: vstate_d = FALL;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            x_q         <= START_X_C;
            y_q         <= START_Y_C;
            vstate_q    <= FALL;
            jcnt_q      <= '0;
            on_ground_q <= 1'b0;
            jumping_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vstate_q    <= vstate_d;
            jcnt_q      <= jcnt_d;
            on_ground_q <= (vstate_d == GROUND);
            jumping_q   <= (vstate_d == JUMP);
        end
    end

    assign char_x    = x_q;
    assign char_y    = y_q;
    assign on_ground = on_ground_q;
    assign jumping   = jumping_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_char_motion_ctrl
//   Drives char_motion_ctrl with a tile-RAM model and compares every motion
//   tick against a per-tick reference model of the motion rules.
// -----------------------------------------------------------------------------
module tb_char_motion_ctrl;

    localparam int COORD_W    = 10;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 960;
    localparam int Y_MIN      = 0;
    localparam int Y_MAX      = 400;
    localparam int START_X    = 244;
    localparam int START_Y    = 300;
    localparam int TICK_DIV   = 16;
    localparam int JUMP_H     = 48;
    localparam int TILE_SHIFT = 5;
    localparam int COL_BITS   = 5;
    localparam int ROW_BITS   = 5;
    localparam int AW         = ROW_BITS + COL_BITS;

    localparam int M_GROUND = 0;
    localparam int M_JUMP   = 1;
    localparam int M_FALL   = 2;

    // ---------------- clock / reset ----------------
    logic                 sys_clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           mov;
    logic [AW-1:0]        blk_addr;
    logic                 blk_data;
    logic [COORD_W-1:0]   char_x;
    logic [COORD_W-1:0]   char_y;
    logic                 on_ground;
    logic                 jumping;
    logic                 tick;

    always #5 sys_clk = ~sys_clk;

    char_motion_ctrl #(
        .COORD_W    (COORD_W),
        .X_MIN      (X_MIN),
        .X_MAX      (X_MAX),
        .Y_MIN      (Y_MIN),
        .Y_MAX      (Y_MAX),
        .START_X    (START_X),
        .START_Y    (START_Y),
        .TICK_DIV   (TICK_DIV),
        .JUMP_H     (JUMP_H),
        .TILE_SHIFT (TILE_SHIFT),
        .COL_BITS   (COL_BITS),
        .ROW_BITS   (ROW_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .mov        (mov),
        .blk_addr   (blk_addr),
        .blk_data   (blk_data),
        .char_x     (char_x),
        .char_y     (char_y),
        .on_ground  (on_ground),
        .jumping    (jumping),
        .tick       (tick)
    );

    // Tile RAM with one cycle of read latency.
    logic tile_map [0:(1<<AW)-1];
    always @(posedge sys_clk) blk_data <= tile_map[blk_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [2*COORD_W-1:0] exp_q[$];

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mx, my, mst, mjc;
    int next_gap;

    function automatic int tile_idx(input int px, input int py);
        int wx, wy;
        wx = px & ((1 << COORD_W) - 1);
        wy = py & ((1 << COORD_W) - 1);
        return (((wy >> TILE_SHIFT) % (1 << ROW_BITS)) << COL_BITS)
             | ((wx >> TILE_SHIFT) % (1 << COL_BITS));
    endfunction

    function automatic bit is_solid(input int px, input int py);
        return tile_map[tile_idx(px, py)];
    endfunction

    task automatic model_reset();
        mx  = START_X;
        my  = START_Y;
        mst = M_FALL;
        mjc = 0;
        exp_q.delete();
        next_gap = TICK_DIV;
    endtask

    task automatic clear_map();
        for (int i = 0; i < (1 << AW); i++) tile_map[i] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (tick !== 1'b1 && n < 64);
    endtask

    // One motion tick: hold mov, check probe addresses, the unchanged outputs
    // just before the update and the new position right after it.
    task automatic run_tick(input logic [3:0] m);
        int gap;
        bit fu, fd, fl, fr;
        int nx, ny, nst, njc;
        int a_u, a_d, a_l, a_r;
        logic [2*COORD_W-1:0] e;
        mov = m;
        wait_tick(gap);
        check("tick_gap", gap, next_gap);
        next_gap = TICK_DIV - 10;

        a_u = tile_idx(mx, my - 1);
        a_d = tile_idx(mx, my + 1);
        a_l = tile_idx(mx - 1, my);
        a_r = tile_idx(mx + 1, my);
        fu = (my > Y_MIN) && !is_solid(mx, my - 1);
        fd = (my < Y_MAX) && !is_solid(mx, my + 1);
        fl = (mx > X_MIN) && !is_solid(mx - 1, my);
        fr = (mx < X_MAX) && !is_solid(mx + 1, my);

        nx = mx;
        if (m[1] && !m[0] && fl)      nx = mx - 1;
        else if (m[0] && !m[1] && fr) nx = mx + 1;

        ny = my; nst = mst; njc = mjc;
        if (mst == M_GROUND) begin
            if (m[3] && fu) begin nst = M_JUMP; ny = my - 1; njc = 1; end
            else if (fd)    begin nst = M_FALL; ny = my + 1; end
        end else if (mst == M_JUMP) begin
            if (fu && mjc < JUMP_H) begin ny = my - 1; njc = mjc + 1; end
            else                    begin nst = M_FALL; njc = 0; end
        end else begin
            if (fd) ny = my + 1;
            else    nst = M_GROUND;
        end
        exp_q.push_back({COORD_W'(ny), COORD_W'(nx)});

        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (i == 1) check("addr_u", int'(blk_addr), a_u);
            if (i == 3) check("addr_d", int'(blk_addr), a_d);
            if (i == 5) check("addr_l", int'(blk_addr), a_l);
            if (i == 7) check("addr_r", int'(blk_addr), a_r);
            if (i == 9) begin
                check("x_hold",   int'(char_x), mx);
                check("y_hold",   int'(char_y), my);
                check("gnd_hold", int'(on_ground), int'(mst == M_GROUND));
                check("tick_len", int'(tick), 0);
            end
        end

        e = exp_q.pop_front();
        check("char_x",    int'(char_x),    int'(e[COORD_W-1:0]));
        check("char_y",    int'(char_y),    int'(e[2*COORD_W-1:COORD_W]));
        check("on_ground", int'(on_ground), int'(nst == M_GROUND));
        check("jumping",   int'(jumping),   int'(nst == M_JUMP));
        mx = nx; my = ny; mst = nst; mjc = njc;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"},    int'(char_x),    START_X);
        check({tag, "_y"},    int'(char_y),    START_Y);
        check({tag, "_gnd"},  int'(on_ground), 0);
        check({tag, "_jmp"},  int'(jumping),   0);
        check({tag, "_tick"}, int'(tick),      0);
        check({tag, "_addr"}, int'(blk_addr),  0);
    endtask

    task automatic run_until_ground(input int limit);
        int k;
        k = 0;
        while (mst != M_GROUND && k < limit) begin
            run_tick(4'b0000);
            k++;
        end
        check("settled", mst, M_GROUND);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int k;
        rst_n = 1'b0;
        mov   = 4'b0000;
        clear_map();
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Empty map: fall from the start height to the floor.
        run_until_ground(150);
        check("floor_y", int'(char_y), Y_MAX);

        // Walk right, then both keys held.
        repeat (5) run_tick(4'b0001);
        check("walk_x", int'(char_x), START_X + 5);
        repeat (3) run_tick(4'b0011);

        // Wall in tile column 8 on the floor row.
        tile_map[(Y_MAX >> TILE_SHIFT) * (1 << COL_BITS) + 8] = 1'b1;
        repeat (10) run_tick(4'b0001);
        check("wall_x", int'(char_x), 255);
        clear_map();

        // Full jump from one pulse of the up key.
        run_tick(4'b1000);
        run_until_ground(200);

        // Ceiling tile in the row above the floor row.
        tile_map[((Y_MAX >> TILE_SHIFT) - 1) * (1 << COL_BITS) + (mx >> TILE_SHIFT)] = 1'b1;
        run_tick(4'b1000);
        run_until_ground(200);
        clear_map();

        // Walk to the right edge and keep pushing.
        k = 0;
        while (mx < X_MAX && k < 800) begin
            run_tick(4'b0001);
            k++;
        end
        repeat (3) run_tick(4'b0001);
        check("xmax_x", int'(char_x), X_MAX);

        // Randomised keys over sparse random maps.
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 0) begin
                for (int t = 0; t < (1 << AW); t++)
                    tile_map[t] = ($urandom_range(0, 7) == 0);
            end
            run_tick(4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a jump, during a probe sequence.
        clear_map();
        run_until_ground(500);
        run_tick(4'b1000);
        repeat (3) run_tick(4'b0000);
        mov = 4'b0000;
        wait_tick(gap);
        check("tick_gap", gap, next_gap);
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_values("midrst");
        rst_n = 1'b1;
        model_reset();
        repeat (4) run_tick(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
